// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and selects the next one from
// exception, stall, return, jump, branch and sequential sources, with a circular RAS.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4,
  localparam int              CW           = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             ret,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] next_address,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misaligned,
  output logic             ras_err,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_inc;
  logic [PW-1:0]    sp_dec;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] raw_target;
  logic             redirect;
  logic             do_push;
  logic             do_pop;
  logic             underflow;

  assign pc_plus4  = address + WIDTH'(INC);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

  // sp names the next free slot; explicit wrap keeps non-power-of-two depths circular
  assign sp_inc  = (sp == PW'(RAS_DEPTH - 1)) ? '0 : sp + 1'b1;
  assign sp_dec  = (sp == '0) ? PW'(RAS_DEPTH - 1) : sp - 1'b1;
  assign ras_top = ras[sp_dec];

  always_comb begin
    raw_target   = pc_plus4;
    redirect     = 1'b0;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    underflow    = 1'b0;
    next_address = pc_plus4;
    if (rst) begin
      next_address = RESET_VECTOR;
    end else if (exc) begin
      next_address = EXC_VECTOR;
    end else if (stall) begin
      next_address = address;
    end else if (ret) begin
      if (ras_empty) begin
        underflow = 1'b1;
      end else begin
        raw_target = ras_top;
        redirect   = 1'b1;
        do_pop     = 1'b1;
      end
    end else if (jump) begin
      raw_target = jump_target;
      redirect   = 1'b1;
      do_push    = call;
    end else if (branch_taken) begin
      raw_target = branch_target;
      redirect   = 1'b1;
    end
    // redirect targets are word-aligned by dropping the two low bits
    if (redirect) begin
      next_address = {raw_target[WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address    <= RESET_VECTOR;
      sp         <= '0;
      ras_count  <= '0;
      misaligned <= 1'b0;
      ras_err    <= 1'b0;
    end else begin
      address    <= next_address;
      misaligned <= redirect && (raw_target[1:0] != 2'b00);
      ras_err    <= underflow;
      if (do_push) begin
        ras[sp] <= pc_plus4;
        sp      <= sp_inc;
        if (!ras_full) begin
          ras_count <= ras_count + 1'b1;
        end
      end else if (do_pop) begin
        sp        <= sp_dec;
        ras_count <= ras_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit: each record drives one cycle and
// carries the hand-computed state expected after that clock edge.
module tb_pc_unit;

  localparam logic [6:0] R  = 7'b1000000;
  localparam logic [6:0] S  = 7'b0100000;
  localparam logic [6:0] E  = 7'b0010000;
  localparam logic [6:0] RT = 7'b0001000;
  localparam logic [6:0] J  = 7'b0000100;
  localparam logic [6:0] C  = 7'b0000010;
  localparam logic [6:0] B  = 7'b0000001;
  localparam logic [6:0] N  = 7'b0000000;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] jt;
    logic [31:0] bt;
    logic [31:0] exp_addr;
    logic [2:0]  exp_cnt;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic        ret = 1'b0;
  logic        jump = 1'b0;
  logic        call = 1'b0;
  logic [31:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] address;
  logic [31:0] next_address;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        ras_err;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .ret(ret), .jump(jump),
    .call(call), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .address(address), .next_address(next_address),
    .pc_plus4(pc_plus4), .misaligned(misaligned), .ras_err(ras_err),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [6:0] ctl, input logic [31:0] jt,
                             input logic [31:0] bt, input logic [31:0] ea,
                             input logic [2:0] ec, input logic em, input logic ee);
    vec_t r;
    r.ctl = ctl; r.jt = jt; r.bt = bt; r.exp_addr = ea;
    r.exp_cnt = ec; r.exp_mis = em; r.exp_err = ee;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t t, input string tag);
    {rst, stall, exc, ret, jump, call, branch_taken} = t.ctl;
    jump_target   = t.jt;
    branch_target = t.bt;
    #1;
    checkOutput({tag, " next_address"}, next_address, t.exp_addr);
    @(posedge clk);
    #1;
    checkOutput({tag, " address"}, address, t.exp_addr);
    checkOutput({tag, " pc_plus4"}, pc_plus4, t.exp_addr + 32'd4);
    checkOutput({tag, " ras_count"}, 32'(ras_count), 32'(t.exp_cnt));
    checkOutput({tag, " ras_empty"}, 32'(ras_empty), 32'(t.exp_cnt == 3'd0));
    checkOutput({tag, " ras_full"}, 32'(ras_full), 32'(t.exp_cnt == 3'd4));
    checkOutput({tag, " misaligned"}, 32'(misaligned), 32'(t.exp_mis));
    checkOutput({tag, " ras_err"}, 32'(ras_err), 32'(t.exp_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset, sequential fetch and stall
    vecs.push_back(v(R,  0, 0, 32'h0,  0, 0, 0));
    vecs.push_back(v(N,  0, 0, 32'h4,  0, 0, 0));
    vecs.push_back(v(N,  0, 0, 32'h8,  0, 0, 0));
    vecs.push_back(v(N,  0, 0, 32'hC,  0, 0, 0));
    vecs.push_back(v(N,  0, 0, 32'h10, 0, 0, 0));
    vecs.push_back(v(S,  0, 0, 32'h10, 0, 0, 0));
    vecs.push_back(v(S,  0, 0, 32'h10, 0, 0, 0));
    vecs.push_back(v(N,  0, 0, 32'h14, 0, 0, 0));
    // nested calls, then priority with a populated RAS
    vecs.push_back(v(J,   32'h10,  0, 32'h10,  0, 0, 0));
    vecs.push_back(v(J|C, 32'h200, 0, 32'h200, 1, 0, 0));
    vecs.push_back(v(J|C, 32'h300, 0, 32'h300, 2, 0, 0));
    vecs.push_back(v(E|RT|J|C|B, 32'h100, 32'h500, 32'h8000_0180, 2, 0, 0));
    vecs.push_back(v(RT|J|C|B,   32'h100, 32'h500, 32'h204,       1, 0, 0));
    vecs.push_back(v(RT, 0, 0, 32'h14, 0, 0, 0));
    // underflow and misaligned targets
    vecs.push_back(v(J,  32'h40,  0, 32'h40,  0, 0, 0));
    vecs.push_back(v(RT, 0,       0, 32'h44,  0, 0, 1));
    vecs.push_back(v(N,  0,       0, 32'h48,  0, 0, 0));
    vecs.push_back(v(J,  32'h103, 0, 32'h100, 0, 1, 0));
    vecs.push_back(v(N,  0,       0, 32'h104, 0, 0, 0));
    vecs.push_back(v(B,   0, 32'h202, 32'h200, 0, 1, 0));
    vecs.push_back(v(S|B, 0, 32'h302, 32'h200, 0, 0, 0));
    vecs.push_back(v(S|E, 0, 0, 32'h8000_0180, 0, 0, 0));
    // overflow: five calls into a four-entry RAS, first return address lost
    vecs.push_back(v(J|C, 32'h1000, 0, 32'h1000, 1, 0, 0));
    vecs.push_back(v(J|C, 32'h2000, 0, 32'h2000, 2, 0, 0));
    vecs.push_back(v(J|C, 32'h3000, 0, 32'h3000, 3, 0, 0));
    vecs.push_back(v(J|C, 32'h4000, 0, 32'h4000, 4, 0, 0));
    vecs.push_back(v(J|C, 32'h5000, 0, 32'h5000, 4, 0, 0));
    vecs.push_back(v(RT, 0, 0, 32'h4004, 3, 0, 0));
    vecs.push_back(v(RT, 0, 0, 32'h3004, 2, 0, 0));
    vecs.push_back(v(RT, 0, 0, 32'h2004, 1, 0, 0));
    vecs.push_back(v(RT, 0, 0, 32'h1004, 0, 0, 0));
    vecs.push_back(v(RT, 0, 0, 32'h1008, 0, 0, 1));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // address wrap at the top of the space
    applyStimulus(v(J, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, 1, 0), "wrap_load");
    applyStimulus(v(N, 0, 0, 32'h0, 0, 0, 0), "wrap_step");

    // reset wins over a simultaneous call and clears the RAS
    applyStimulus(v(J|C,   32'h600, 0, 32'h600, 1, 0, 0), "pre_reset_call");
    applyStimulus(v(R|J|C, 32'h700, 0, 32'h0,   0, 0, 0), "reset_with_call");
    applyStimulus(v(RT, 0, 0, 32'h4, 0, 0, 1), "ret_after_reset");
    applyStimulus(v(N,  0, 0, 32'h8, 0, 0, 0), "err_clears");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS core: it holds the fetch address and computes the next one from sequential, branch, jump, return and exception requests. It supports stall and carries a small circular return-address stack (RAS) for call/return. It replaces the plain PC register, which only loaded an externally supplied next address. The unit drives the instruction-memory address and exports `pc_plus4` to the link/branch datapath.

## Interface

Parameters:
- `WIDTH`, 32, address width in bits.
- `RESET_VECTOR`, 32'h0000_0000, `address` value after reset.
- `EXC_VECTOR`, 32'h8000_0180, exception handler entry.
- `INC`, 4, sequential increment in bytes.
- `RAS_DEPTH`, 4, number of RAS entries (≥2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold PC; suppresses all redirects except exception.
- `exc`  in  1  exception request.
- `ret`  in  1  return: next PC = RAS top, then pop.
- `jump`  in  1  unconditional jump to `jump_target`.
- `call`  in  1  qualifies `jump`: push `pc_plus4` onto RAS.
- `jump_target`  in  WIDTH  jump destination.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  WIDTH  branch destination.
- `address`  out  WIDTH  current PC (registered).
- `next_address`  out  WIDTH  PC value for the next edge (combinational).
- `pc_plus4`  out  WIDTH  `address + INC`, modulo 2^WIDTH.
- `misaligned`  out  1  registered one-cycle pulse: the last loaded redirect target had nonzero bits [1:0].
- `ras_err`  out  1  registered one-cycle pulse: `ret` was taken with the RAS empty.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- `ras_empty` / `ras_full`  out  1  `ras_count == 0` / `ras_count == RAS_DEPTH`.

## Operation

- Next-PC selection, in priority order:
  1. `exc`: `EXC_VECTOR`. Applies even when `stall` is high.
  2. `stall`: hold `address`.
  3. `ret`: RAS top. If the RAS is empty, select `pc_plus4` and pulse `ras_err`.
  4. `jump`: `jump_target`.
  5. `branch_taken`: `branch_target`.
  6. Otherwise: `pc_plus4`.
- Redirect targets (`jump_target`, `branch_target`, RAS top) load with bits [1:0] forced to 0. If either of those bits was set, `misaligned` pulses for one cycle. `EXC_VECTOR` and `RESET_VECTOR` load unmodified.
- RAS push: occurs when `call && jump` is the selected source, i.e. not `exc`, not `stall`, not `ret`. The pushed value is `pc_plus4`. `call` without `jump` is ignored.
- Push when full: the oldest entry is overwritten (circular buffer) and `ras_count` stays at `RAS_DEPTH`.
- RAS pop: occurs when `ret` is the selected source and the RAS is non-empty; `ras_count` decrements.
- `ret` together with `call`: pop only, no push.
- `exc` and `stall` suppress all push and pop; RAS contents are preserved across an exception.
- Arithmetic wraps modulo 2^WIDTH: `address = 2^WIDTH - INC` → `pc_plus4 = 0`.

## Timing

- Reset, on the first rising edge with `rst = 1`:
  - `address = RESET_VECTOR`, `ras_count = 0`, `misaligned = 0`, `ras_err = 0`.
  - RAS pointers cleared.
  - `rst` overrides every other input, including `exc`.
- Reset asserted mid-operation discards any pending push or pop on that edge.
- `next_address` is combinational from the current inputs and state. It equals the `address` value after the next edge; there is zero-cycle redirect latency from a request to `next_address`.
- `misaligned` and `ras_err` are valid in the cycle after the offending edge and are high for exactly one cycle per event.
- `ras_count`, `ras_empty` and `ras_full` update on the same edge as the push or pop.
- Back-to-back `ret` on consecutive cycles pops successive entries (LIFO), one per cycle.

## Test plan

- Reset and sequential:
  - `rst` 1 cycle, then 4 idle cycles → `address` 0, 4, 8, 12, 16.
  - `stall` 2 cycles at 16 → `address` holds 16, then 20.
- Priority:
  - Same cycle: `exc`, `ret`, `jump` (target 32'h100), `branch_taken` → `address = 32'h8000_0180`, RAS unchanged.
  - Drop `exc` → `ret` wins.
- Call/return nesting:
  - `call+jump` at 0x10 → 0x200; `call+jump` at 0x200 → 0x300.
  - Then two `ret` → `address` 0x204, then 0x14; `ras_count` 2 → 1 → 0.
- RAS overflow:
  - 5 calls with `RAS_DEPTH = 4` → `ras_count` stays 4, `ras_full = 1`.
  - 4 returns yield the last 4 pushed return addresses; the first pushed address is lost.
- Underflow and misalignment:
  - `ret` with RAS empty at 0x40 → `address = 0x44`, `ras_err` pulses 1 cycle.
  - `jump_target = 0x103` → `address = 0x100`, `misaligned` pulses.
- Wrap and reset:
  - `address = 32'hFFFF_FFFC`, idle → `address = 0`.
  - `rst` together with `call+jump` → `address = RESET_VECTOR`, `ras_count = 0`.
